// File: rtl/intfac_pkg.sv
// Shared constants for the integer-factoring controllers: FSM encoding and the
// trial-divisor range.
package intfac_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_SKIP  = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  localparam int unsigned D_FIRST = 2;
  localparam int unsigned D_LAST  = 15;

endpackage

// File: rtl/smallest_factor_22_4.sv
// Smallest-factor search by trial division through an external remainder unit.
// Optional macro SQRT_EARLY_EXIT_EN stops the search once d*d exceeds n.
module smallest_factor_22_4
  import intfac_pkg::*;
#(
  parameter int unsigned N_W = 22,
  parameter int unsigned D_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] n,
  output logic [D_W-1:0] factor,
  output logic           found,
  output logic           result_ready,
  output logic           rem_start,
  output logic [N_W-1:0] rem_dividend,
  output logic [D_W-1:0] rem_divisor,
  input  logic [D_W-1:0] rem_result,
  input  logic           rem_ready
);

  logic [1:0]     state_q, state_d;
  logic [N_W-1:0] n_r, n_d;
  logic [D_W-1:0] d_q, d_d;
  logic [D_W-1:0] factor_q, factor_d;
  logic           found_q, found_d;
  logic           early_exit;

`ifdef SQRT_EARLY_EXIT_EN
  logic [2*D_W-1:0] d_sq;
  assign d_sq       = {{D_W{1'b0}}, d_q} * {{D_W{1'b0}}, d_q};
  assign early_exit = (N_W'(d_sq) > n_r);
`else
  assign early_exit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    n_d      = n_r;
    d_d      = d_q;
    factor_d = factor_q;
    found_d  = found_q;
    if (start) begin
      n_d      = n;
      d_d      = D_W'(D_FIRST);
      factor_d = '0;
      found_d  = 1'b0;
      state_d  = (n < N_W'(2)) ? ST_IDLE : ST_ISSUE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_ISSUE: state_d = early_exit ? ST_IDLE : ST_SKIP;
        // rem_ready still reflects the previous operation during this cycle
        ST_SKIP:  state_d = ST_WAIT;
        ST_WAIT: begin
          if (rem_ready) begin
            if (rem_result == '0) begin
              factor_d = d_q;
              found_d  = 1'b1;
              state_d  = ST_IDLE;
            end else if (d_q == D_W'(D_LAST)) begin
              state_d = ST_IDLE;
            end else begin
              d_d     = d_q + D_W'(1);
              state_d = ST_ISSUE;
            end
          end
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      n_r      <= '0;
      d_q      <= D_W'(D_FIRST);
      factor_q <= '0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_r      <= n_d;
      d_q      <= d_d;
      factor_q <= factor_d;
      found_q  <= found_d;
    end
  end

  assign rem_start    = (state_q == ST_ISSUE) & ~early_exit;
  assign rem_dividend = n_r;
  assign rem_divisor  = d_q;
  assign factor       = factor_q;
  assign found        = found_q;
  assign result_ready = (state_q == ST_IDLE) & ~start;

endmodule

// File: tb/tb_smallest_factor_22_4.sv
// Directed bench for smallest_factor_22_4 with a behavioural remainder unit whose
// ready flag drops one cycle after rem_start (stale result visible in SKIP).
module tb_smallest_factor_22_4;

  localparam int unsigned N_W = 22;
  localparam int unsigned D_W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [N_W-1:0] n = '0;
  logic [D_W-1:0] factor;
  logic           found;
  logic           result_ready;
  logic           rem_start;
  logic [N_W-1:0] rem_dividend;
  logic [D_W-1:0] rem_divisor;
  logic [D_W-1:0] rem_result;
  logic           rem_ready;

  int checks = 0;
  int errors = 0;
  int pulse_total = 0;
  logic [D_W-1:0] div_log [256];
  bit zero_div = 1'b0;

  smallest_factor_22_4 #(.N_W(N_W), .D_W(D_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n),
    .factor(factor), .found(found), .result_ready(result_ready),
    .rem_start(rem_start), .rem_dividend(rem_dividend), .rem_divisor(rem_divisor),
    .rem_result(rem_result), .rem_ready(rem_ready)
  );

  always #5 clk = ~clk;

  // Remainder unit model: ready falls one cycle after rem_start, result after 3 more.
  logic [N_W-1:0] m_a;
  logic [D_W-1:0] m_b;
  logic [1:0]     m_cnt;
  logic           m_start_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_ready  <= 1'b1;
      rem_result <= '0;
      m_a        <= '0;
      m_b        <= '0;
      m_cnt      <= '0;
      m_start_d  <= 1'b0;
    end else begin
      m_start_d <= rem_start;
      if (rem_start) begin
        m_a <= rem_dividend;
        m_b <= rem_divisor;
      end
      if (m_start_d) begin
        rem_ready <= 1'b0;
        m_cnt     <= 2'd2;
      end else if (!rem_ready) begin
        if (m_cnt == 2'd0) begin
          rem_ready  <= 1'b1;
          rem_result <= (m_b == '0) ? '0 : D_W'(m_a % N_W'(m_b));
        end else begin
          m_cnt <= m_cnt - 2'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rem_start) begin
      div_log[pulse_total[7:0]] = rem_divisor;
      if (rem_divisor == '0) zero_div = 1'b1;
      pulse_total++;
    end
  end

  task automatic do_start(input logic [N_W-1:0] v, output int base);
    @(negedge clk);
    start = 1'b1;
    n = v;
    #1;
    base = pulse_total;
    checks++;
    if (result_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_cycle_ready n=%0d: got %b want 0", v, result_ready);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    #1;
    for (int i = 0; i < max; i++) begin
      if (result_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (rem_start !== 1'b0) begin errors++; $display("FAIL rst_rem_start: got %b want 0", rem_start); end
    checks++;
    if (factor !== '0 || found !== 1'b0) begin
      errors++; $display("FAIL rst_result: got %0d/%b want 0/0", factor, found);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (result_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", result_ready); end
  endtask

  task automatic test_composite_91;
    int base;
    bit ok;
    bit seq_ok;
    do_start(22'd91, base);
    wait_done(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL n91_timeout: got no result_ready want 1"); end
    checks++;
    if (factor !== 4'd7 || found !== 1'b1) begin
      errors++; $display("FAIL n91_result: got %0d/%b want 7/1", factor, found);
    end
    checks++;
    if (pulse_total - base != 6) begin
      errors++; $display("FAIL n91_pulses: got %0d want 6", pulse_total - base);
    end
    seq_ok = 1'b1;
    for (int i = 0; i < 6; i++)
      if (div_log[8'(base + i)] !== 4'(i + 2)) seq_ok = 1'b0;
    checks++;
    if (!seq_ok) begin errors++; $display("FAIL n91_divisors: got bad sequence want 2..7"); end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (factor !== 4'd7 || found !== 1'b1 || result_ready !== 1'b1) begin
      errors++; $display("FAIL n91_hold: got %0d/%b/%b want 7/1/1", factor, found, result_ready);
    end
  endtask

  task automatic test_small_n;
    logic [N_W-1:0] vals [2];
    int base;
    vals[0] = 22'd1;
    vals[1] = 22'd0;
    for (int k = 0; k < 2; k++) begin
      do_start(vals[k], base);
      #1;
      checks++;
      if (result_ready !== 1'b1) begin
        errors++; $display("FAIL small_ready n=%0d: got %b want 1", vals[k], result_ready);
      end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (factor !== '0 || found !== 1'b0 || pulse_total != base) begin
        errors++;
        $display("FAIL small_result n=%0d: got %0d/%b pulses %0d want 0/0 pulses 0",
                 vals[k], factor, found, pulse_total - base);
      end
    end
  endtask

  task automatic test_prime_17;
    int base;
    bit ok;
    int exp_p;
`ifdef SQRT_EARLY_EXIT_EN
    exp_p = 3;
`else
    exp_p = 14;
`endif
    do_start(22'd17, base);
    wait_done(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL n17_timeout: got no result_ready want 1"); end
    checks++;
    if (pulse_total - base != exp_p) begin
      errors++; $display("FAIL n17_pulses: got %0d want %0d", pulse_total - base, exp_p);
    end
    checks++;
    if (factor !== '0 || found !== 1'b0) begin
      errors++; $display("FAIL n17_result: got %0d/%b want 0/0", factor, found);
    end
    checks++;
    if (zero_div !== 1'b0) begin errors++; $display("FAIL zero_divisor: got 1 want 0"); end
  endtask

  task automatic test_self_factor;
    logic [N_W-1:0] vals [2];
    logic [D_W-1:0] exp_f [2];
    logic           exp_v [2];
    int base;
    bit ok;
    vals[0] = 22'd13;
    vals[1] = 22'd2;
`ifdef SQRT_EARLY_EXIT_EN
    exp_f[0] = 4'd0;  exp_v[0] = 1'b0;
    exp_f[1] = 4'd0;  exp_v[1] = 1'b0;
`else
    exp_f[0] = 4'd13; exp_v[0] = 1'b1;
    exp_f[1] = 4'd2;  exp_v[1] = 1'b1;
`endif
    for (int k = 0; k < 2; k++) begin
      do_start(vals[k], base);
      wait_done(400, ok);
      checks++;
      if (!ok || factor !== exp_f[k] || found !== exp_v[k]) begin
        errors++;
        $display("FAIL self_factor n=%0d: got %0d/%b ok=%b want %0d/%b",
                 vals[k], factor, found, ok, exp_f[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_max;
    int base;
    bit ok;
    do_start(22'd4194303, base);
    wait_done(300, ok);
    checks++;
    if (!ok || factor !== 4'd3 || found !== 1'b1) begin
      errors++; $display("FAIL max_n: got %0d/%b ok=%b want 3/1", factor, found, ok);
    end
    checks++;
    if (pulse_total - base != 2) begin
      errors++; $display("FAIL max_pulses: got %0d want 2", pulse_total - base);
    end
  endtask

  task automatic test_restart;
    int base;
    bit ok;
    bit seen;
    do_start(22'd17, base);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pulse_total > base) begin seen = 1'b1; break; end
      @(negedge clk);
      #1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL restart_first_pulse: got none want 1"); end
    // Land the new start so the old op's nonzero result is stale in the new SKIP
    repeat (4) @(negedge clk);
    start = 1'b1;
    n = 22'd10;
    @(negedge clk);
    start = 1'b0;
    wait_done(300, ok);
    checks++;
    if (!ok || factor !== 4'd2 || found !== 1'b1) begin
      errors++; $display("FAIL restart_result: got %0d/%b ok=%b want 2/1", factor, found, ok);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    bit seen;
    do_start(22'd91, base);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pulse_total > base) begin seen = 1'b1; break; end
      @(negedge clk);
      #1;
    end
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!seen || rem_start !== 1'b0 || found !== 1'b0 || factor !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got seen=%b rem_start=%b %0d/%b want 1 0 0/0",
               seen, rem_start, factor, found);
    end
    @(negedge clk);
    rst_n = 1'b1;
    base = pulse_total;
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (pulse_total != base || result_ready !== 1'b1 || found !== 1'b0 || factor !== '0) begin
      errors++;
      $display("FAIL midreset_after: got pulses %0d ready %b %0d/%b want 0 1 0/0",
               pulse_total - base, result_ready, factor, found);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    bit ok;
    do_start(22'd6, base);
    wait_done(300, ok);
    checks++;
    if (!ok || factor !== 4'd2 || found !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got %0d/%b ok=%b want 2/1", factor, found, ok);
    end
    do_start(22'd9, base);
    wait_done(300, ok);
    checks++;
    if (!ok || factor !== 4'd3 || found !== 1'b1) begin
      errors++; $display("FAIL b2b_second: got %0d/%b ok=%b want 3/1", factor, found, ok);
    end
  endtask

  initial begin
    test_reset();
    test_composite_91();
    test_small_n();
    test_prime_17();
    test_self_factor();
    test_max();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
